if_id_skid_reg: RTL

//  IF/ID pipeline register for the MIPS core, implemented as a 2-entry skid buffer.

---
 rtl/if_id_skid_reg.sv | 113 +++++++++++
 1 files changed

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register built as a 2-entry skid buffer. The main entry drives the
// decode-side fields and the skid entry absorbs one beat while decode is stalled.
module if_id_skid_reg #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc4,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc4,
    output logic [5:0]         out_opcode,
    output logic [4:0]         out_rs,
    output logic [4:0]         out_rt,
    output logic [4:0]         out_rd,
    output logic [4:0]         out_shamt,
    output logic [5:0]         out_funct,
    output logic [15:0]        out_imm16,
    output logic [25:0]        out_target,
    output logic [CNT_W-1:0]   stall_cnt
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t             state;
    logic [INSTR_W-1:0] main_instr;
    logic [PC_W-1:0]    main_pc4;
    logic [INSTR_W-1:0] skid_instr;
    logic [PC_W-1:0]    skid_pc4;
    logic               accept;
    logic               pop;

    assign accept = in_valid && in_ready && !flush;
    assign pop    = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
            main_instr <= '0;
            main_pc4   <= '0;
            skid_instr <= '0;
            skid_pc4   <= '0;
            stall_cnt  <= '0;
        end else if (flush) begin
            // Flush wins over both accept and pop; the payload registers keep stale data.
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            stall_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);

            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_instr <= in_instr;
                        main_pc4   <= in_pc4;
                        state      <= ONE;
                        out_valid  <= 1'b1;
                        in_ready   <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_instr <= in_instr;
                        main_pc4   <= in_pc4;
                    end else if (accept) begin
                        skid_instr <= in_instr;
                        skid_pc4   <= in_pc4;
                        state      <= TWO;
                        in_ready   <= 1'b0;
                    end else if (pop) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                TWO: begin
                    if (pop) begin
                        main_instr <= skid_instr;
                        main_pc4   <= skid_pc4;
                        state      <= ONE;
                        in_ready   <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign out_pc4    = main_pc4;
    assign out_opcode = main_instr[31:26];
    assign out_rs     = main_instr[25:21];
    assign out_rt     = main_instr[20:16];
    assign out_rd     = main_instr[15:11];
    assign out_shamt  = main_instr[10:6];
    assign out_funct  = main_instr[5:0];
    assign out_imm16  = main_instr[15:0];
    assign out_target = main_instr[25:0];

endmodule
